axil_arbiter_2x1: RTL and testbench
===================================

AXIL_ARBITER_2X1 -- requirements
Module: axil_arbiter_2x1

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, AXI-Lite address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; strobe width = DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port group s0_* (slave, requester 0, highest priority after reset), one signal per line:
- awaddr in ADDR_WIDTH; awprot in 3; awvalid in 1; awready out 1.
- wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wvalid in 1; wready out 1.
- bresp out 2; bvalid out 1; bready in 1.
- araddr in ADDR_WIDTH; arprot in 3; arvalid in 1; arready out 1.
- rdata out DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1.
REQ-006 SHALL have port group s1_* (slave, requester 1): the same signals, widths and directions as s0_*.
REQ-007 SHALL have port group m_* (master, toward the peripheral interconnect): the same signals as s0_*, with every direction inverted.

Function
REQ-008 Write path and read path SHALL be arbitrated independently; each path SHALL hold at most one outstanding transaction.
REQ-009 Write FSM states SHALL be W_IDLE, W_FWD, W_RESP; read FSM states SHALL be R_IDLE, R_FWD, R_RESP.
REQ-010 In W_IDLE, a write request is sx_awvalid=1 or sx_wvalid=1; with any request present, the FSM SHALL latch the grant and move to W_FWD on the next edge.
REQ-011 In R_IDLE, a read request is sx_arvalid=1; with any request present, the FSM SHALL latch the grant and move to R_FWD on the next edge.
REQ-012 Arbitration SHALL be round-robin per path: a single requester wins; when both request, the requester not granted last on that path wins; each path's last-grant pointer resets to 1, so s0 wins the first tie.
REQ-013 In W_FWD, m_aw* and m_w* SHALL combinationally mirror the granted requester's aw*/w*.
REQ-014 In W_FWD, each of m_awvalid and m_wvalid SHALL be gated off once that channel has handshaken; per-channel done flags SHALL be held.
REQ-015 In W_FWD, the granted sx_awready/sx_wready SHALL mirror m_awready/m_wready with the same gating.
REQ-016 W_FWD SHALL go to W_RESP on the edge where both aw and w are complete, including the case where both handshake in the same cycle.
REQ-017 In W_RESP, m_bready SHALL equal the granted sx_bready, the granted sx_bvalid/bresp SHALL mirror m_bvalid/m_bresp, and the FSM SHALL return to W_IDLE on the b handshake.
REQ-018 R_FWD SHALL forward ar the same way and go to R_RESP on the ar handshake; R_RESP SHALL route r back to the granted requester and return to R_IDLE on the r handshake.
REQ-019 A non-granted requester SHALL see all of its ready and valid outputs at 0, with bresp/rresp/rdata driven 0.
REQ-020 Latency: request visible in IDLE at cycle N -> m_*valid asserted at cycle N+1; response handshake at cycle M -> path idle and re-arbitrates at cycle M+1.
REQ-021 Back-to-back ties SHALL alternate grants s0, s1, s0, ... with no idle cycle beyond REQ-020.
REQ-022 The arbiter SHALL NOT alter address, prot, data, strobe or response values; address decode belongs to the downstream interconnect.
REQ-023 Read and write transactions from different requesters SHALL proceed concurrently without interaction.

Reset
REQ-024 While rst=1, both FSMs SHALL be IDLE, done flags 0, last-grant pointers 1, and every valid/ready output on s0_*, s1_* and m_* SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abandon that transaction without completion; after rst deasserts, arbitration SHALL restart per REQ-012.

Verification
REQ-026 s0 writes addr 0x010004, data 0xA5A5A5A5, strb 0xF, with m_awready/m_wready=1 and bvalid one cycle later -> m_awvalid at N+1, s0_bvalid=1, bresp=0, s1 sees nothing.
REQ-027 s0 and s1 both hold arvalid from reset, with addrs 0x000000 and 0x010000 -> m_araddr shows 0x000000 first, then 0x010000; rdata 0x12345678 is returned to the correct requester each time.
REQ-028 s1 presents wvalid two cycles before awvalid, with m_*ready=1 -> exactly one aw and one w handshake on m_*, and no second handshake.
REQ-029 s0 write and s1 read are issued in the same cycle -> both are forwarded at N+1 and complete independently.
REQ-030 rst=1 for 1 cycle while in W_RESP -> all valids are 0 the next cycle; a subsequent s1 write completes normally.
REQ-031 s0 and s1 write continuously for 8 transactions -> grant order is s0,s1,s0,s1,s0,s1,s0,s1.

Source files
------------

// File: rtl/axil_arbiter_2x1.sv
// Two-requester AXI-Lite arbiter; independent round-robin write and read paths, one outstanding txn each.
// Latency: request seen in IDLE at cycle N -> m_*valid at N+1; response handshake at M -> re-arbitrates at M+1.
// Backpressure: ready/valid passed straight through to the granted requester; the other requester sees all zeros.
module axil_arbiter_2x1 #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  // requester 0
  input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
  input  logic [2:0]                s0_awprot,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_WIDTH-1:0]     s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ADDR_WIDTH-1:0]     s0_araddr,
  input  logic [2:0]                s0_arprot,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
  input  logic [2:0]                s1_awprot,
  input  logic                      s1_awvalid,
  output logic                      s1_awready,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                      s1_wvalid,
  output logic                      s1_wready,
  output logic [1:0]                s1_bresp,
  output logic                      s1_bvalid,
  input  logic                      s1_bready,
  input  logic [ADDR_WIDTH-1:0]     s1_araddr,
  input  logic [2:0]                s1_arprot,
  input  logic                      s1_arvalid,
  output logic                      s1_arready,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic [1:0]                s1_rresp,
  output logic                      s1_rvalid,
  input  logic                      s1_rready,
  // toward the peripheral interconnect
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} rd_state_t;

  wr_state_t r_wr_state, w_wr_state_nxt;
  logic      r_wr_gnt, w_wr_gnt_nxt;
  logic      r_wr_last, w_wr_last_nxt;
  logic      r_aw_done, w_aw_done_nxt;
  logic      r_w_done, w_w_done_nxt;

  rd_state_t r_rd_state, w_rd_state_nxt;
  logic      r_rd_gnt, w_rd_gnt_nxt;
  logic      r_rd_last, w_rd_last_nxt;

  // A write request is either half of a write; reads only have ar
  logic w_wr_req0, w_wr_req1, w_rd_req0, w_rd_req1;
  logic w_sel_awvalid, w_sel_wvalid, w_sel_bready, w_sel_arvalid, w_sel_rready;
  logic w_aw_hs, w_w_hs;

  assign w_wr_req0 = s0_awvalid | s0_wvalid;
  assign w_wr_req1 = s1_awvalid | s1_wvalid;
  assign w_rd_req0 = s0_arvalid;
  assign w_rd_req1 = s1_arvalid;

  assign w_sel_awvalid = r_wr_gnt ? s1_awvalid : s0_awvalid;
  assign w_sel_wvalid  = r_wr_gnt ? s1_wvalid  : s0_wvalid;
  assign w_sel_bready  = r_wr_gnt ? s1_bready  : s0_bready;
  assign w_sel_arvalid = r_rd_gnt ? s1_arvalid : s0_arvalid;
  assign w_sel_rready  = r_rd_gnt ? s1_rready  : s0_rready;

  // Payload is never modified, only steered by the held grant
  assign m_awaddr = r_wr_gnt ? s1_awaddr : s0_awaddr;
  assign m_awprot = r_wr_gnt ? s1_awprot : s0_awprot;
  assign m_wdata  = r_wr_gnt ? s1_wdata  : s0_wdata;
  assign m_wstrb  = r_wr_gnt ? s1_wstrb  : s0_wstrb;
  assign m_araddr = r_rd_gnt ? s1_araddr : s0_araddr;
  assign m_arprot = r_rd_gnt ? s1_arprot : s0_arprot;

  // State, grant, last-grant pointers and per-channel done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_gnt   <= 1'b0;
      r_wr_last  <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rd_state <= R_IDLE;
      r_rd_gnt   <= 1'b0;
      r_rd_last  <= 1'b1;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_gnt   <= w_wr_gnt_nxt;
      r_wr_last  <= w_wr_last_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_rd_gnt   <= w_rd_gnt_nxt;
      r_rd_last  <= w_rd_last_nxt;
    end
  end

  // Write path: arbitrate, forward aw/w with per-channel completion, route b back
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_gnt_nxt   = r_wr_gnt;
    w_wr_last_nxt  = r_wr_last;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    s0_awready = 1'b0;
    s0_wready  = 1'b0;
    s0_bvalid  = 1'b0;
    s0_bresp   = 2'b00;
    s1_awready = 1'b0;
    s1_wready  = 1'b0;
    s1_bvalid  = 1'b0;
    s1_bresp   = 2'b00;
    w_aw_hs    = 1'b0;
    w_w_hs     = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (w_wr_req0 | w_wr_req1) begin
          // On a tie the requester not granted last time wins
          w_wr_gnt_nxt   = (w_wr_req0 & w_wr_req1) ? ~r_wr_last : w_wr_req1;
          w_wr_last_nxt  = w_wr_gnt_nxt;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_wr_state_nxt = W_FWD;
        end
      end
      W_FWD: begin
        m_awvalid  = w_sel_awvalid & ~r_aw_done;
        m_wvalid   = w_sel_wvalid & ~r_w_done;
        s0_awready = ~r_wr_gnt & m_awready & ~r_aw_done;
        s0_wready  = ~r_wr_gnt & m_wready & ~r_w_done;
        s1_awready = r_wr_gnt & m_awready & ~r_aw_done;
        s1_wready  = r_wr_gnt & m_wready & ~r_w_done;
        w_aw_hs    = m_awvalid & m_awready;
        w_w_hs     = m_wvalid & m_wready;
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_wr_state_nxt = W_RESP;
        end else begin
          w_aw_done_nxt = r_aw_done | w_aw_hs;
          w_w_done_nxt  = r_w_done | w_w_hs;
        end
      end
      W_RESP: begin
        m_bready = w_sel_bready;
        if (r_wr_gnt) begin
          s1_bvalid = m_bvalid;
          s1_bresp  = m_bresp;
        end else begin
          s0_bvalid = m_bvalid;
          s0_bresp  = m_bresp;
        end
        if (m_bvalid & m_bready) begin
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
    // Outputs are quiet for the whole reset window, not just after the first edge
    if (rst) begin
      m_awvalid  = 1'b0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      s0_awready = 1'b0;
      s0_wready  = 1'b0;
      s0_bvalid  = 1'b0;
      s0_bresp   = 2'b00;
      s1_awready = 1'b0;
      s1_wready  = 1'b0;
      s1_bvalid  = 1'b0;
      s1_bresp   = 2'b00;
    end
  end

  // Read path: arbitrate, forward ar, route r back
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_gnt_nxt   = r_rd_gnt;
    w_rd_last_nxt  = r_rd_last;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s0_rdata   = '0;
    s0_rresp   = 2'b00;
    s1_arready = 1'b0;
    s1_rvalid  = 1'b0;
    s1_rdata   = '0;
    s1_rresp   = 2'b00;
    case (r_rd_state)
      R_IDLE: begin
        if (w_rd_req0 | w_rd_req1) begin
          w_rd_gnt_nxt   = (w_rd_req0 & w_rd_req1) ? ~r_rd_last : w_rd_req1;
          w_rd_last_nxt  = w_rd_gnt_nxt;
          w_rd_state_nxt = R_FWD;
        end
      end
      R_FWD: begin
        m_arvalid  = w_sel_arvalid;
        s0_arready = ~r_rd_gnt & m_arready;
        s1_arready = r_rd_gnt & m_arready;
        if (m_arvalid & m_arready) begin
          w_rd_state_nxt = R_RESP;
        end
      end
      R_RESP: begin
        m_rready = w_sel_rready;
        if (r_rd_gnt) begin
          s1_rvalid = m_rvalid;
          s1_rdata  = m_rdata;
          s1_rresp  = m_rresp;
        end else begin
          s0_rvalid = m_rvalid;
          s0_rdata  = m_rdata;
          s0_rresp  = m_rresp;
        end
        if (m_rvalid & m_rready) begin
          w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
    if (rst) begin
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      s0_arready = 1'b0;
      s0_rvalid  = 1'b0;
      s0_rdata   = '0;
      s0_rresp   = 2'b00;
      s1_arready = 1'b0;
      s1_rvalid  = 1'b0;
      s1_rdata   = '0;
      s1_rresp   = 2'b00;
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Bench for axil_arbiter_2x1: cycle-by-cycle vector table plus directed multi-cycle sequences.
// Inputs are driven just after the falling edge and outputs sampled 1ns later.
// Every loop is bounded by a cycle count so the run always reaches its summary.
module tb_axil_arbiter_2x1;
  localparam int AW = 24;
  localparam int DW = 32;

  logic clk, rst;
  logic [AW-1:0] s0_awaddr, s1_awaddr, m_awaddr, s0_araddr, s1_araddr, m_araddr;
  logic [2:0] s0_awprot, s1_awprot, m_awprot, s0_arprot, s1_arprot, m_arprot;
  logic s0_awvalid, s0_awready, s1_awvalid, s1_awready, m_awvalid, m_awready;
  logic [DW-1:0] s0_wdata, s1_wdata, m_wdata, s0_rdata, s1_rdata, m_rdata;
  logic [DW/8-1:0] s0_wstrb, s1_wstrb, m_wstrb;
  logic s0_wvalid, s0_wready, s1_wvalid, s1_wready, m_wvalid, m_wready;
  logic [1:0] s0_bresp, s1_bresp, m_bresp, s0_rresp, s1_rresp, m_rresp;
  logic s0_bvalid, s0_bready, s1_bvalid, s1_bready, m_bvalid, m_bready;
  logic s0_arvalid, s0_arready, s1_arvalid, s1_arready, m_arvalid, m_arready;
  logic s0_rvalid, s0_rready, s1_rvalid, s1_rready, m_rvalid, m_rready;

  axil_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s0_araddr(s0_araddr), .s0_arprot(s0_arprot), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .s1_araddr(s1_araddr), .s1_arprot(s1_arprot), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Input vector bit order (MSB first):
  // rst | s0_awv s0_wv s1_awv s1_wv | m_awr m_wr m_bv s0_br s1_br | s0_arv s1_arv m_arr m_rv s0_rr s1_rr
  task automatic apply_in(input logic [15:0] v);
    {rst, s0_awvalid, s0_wvalid, s1_awvalid, s1_wvalid,
     m_awready, m_wready, m_bvalid, s0_bready, s1_bready,
     s0_arvalid, s1_arvalid, m_arready, m_rvalid, s0_rready, s1_rready} = v;
  endtask

  // Observed vector bit order (MSB first):
  // m_awv m_wv m_br m_arv m_rr | s0_awr s0_wr s0_bv | s1_awr s1_wr s1_bv | s0_arr s0_rv s1_arr s1_rv
  function automatic logic [14:0] obs();
    return {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
            s0_awready, s0_wready, s0_bvalid, s1_awready, s1_wready, s1_bvalid,
            s0_arready, s0_rvalid, s1_arready, s1_rvalid};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    apply_in(16'b1_0000_00000_000000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] vin;
    logic [14:0] vexp;
  } vec_t;

  vec_t tbl[31];
  logic [AW-1:0] q_ar[$];
  logic hs0, hs1, hs_aw, hs_w, hs_b;
  int k, n_aw, n_w, n_b, nr0, nr1;

  initial begin
    rst = 1'b1;
    apply_in(16'b1_0000_00000_000000);
    s0_awaddr = '0; s0_awprot = '0; s0_wdata = '0; s0_wstrb = '0; s0_araddr = '0; s0_arprot = '0;
    s1_awaddr = '0; s1_awprot = '0; s1_wdata = '0; s1_wstrb = '0; s1_araddr = '0; s1_arprot = '0;
    m_bresp = '0; m_rdata = '0; m_rresp = '0;

    // Cycle-by-cycle table: reset, s0 write, tie->s1 with aw-before-w, reset in W_RESP, reads
    tbl[0]  = '{16'b1_0000_00000_000000, 15'b00000_000_000_0000};
    tbl[1]  = '{16'b1_1111_11111_111111, 15'b00000_000_000_0000};
    tbl[2]  = '{16'b0_1100_11000_000000, 15'b00000_000_000_0000};
    tbl[3]  = '{16'b0_1100_11000_000000, 15'b11000_110_000_0000};
    tbl[4]  = '{16'b0_0000_11110_000000, 15'b00100_001_000_0000};
    tbl[5]  = '{16'b0_0000_11000_000000, 15'b00000_000_000_0000};
    tbl[6]  = '{16'b0_1111_00000_000000, 15'b00000_000_000_0000};
    tbl[7]  = '{16'b0_1111_00000_000000, 15'b11000_000_000_0000};
    tbl[8]  = '{16'b0_1111_10000_000000, 15'b11000_000_100_0000};
    tbl[9]  = '{16'b0_1111_11000_000000, 15'b01000_000_010_0000};
    tbl[10] = '{16'b0_1100_00001_000000, 15'b00100_000_000_0000};
    tbl[11] = '{16'b0_1100_00100_000000, 15'b00000_000_001_0000};
    tbl[12] = '{16'b0_1100_00101_000000, 15'b00100_000_001_0000};
    tbl[13] = '{16'b0_1100_00000_000000, 15'b00000_000_000_0000};
    tbl[14] = '{16'b0_1100_00000_000000, 15'b11000_000_000_0000};
    tbl[15] = '{16'b0_1100_11000_000000, 15'b11000_110_000_0000};
    tbl[16] = '{16'b0_0000_00010_000000, 15'b00100_000_000_0000};
    tbl[17] = '{16'b1_0000_00110_000000, 15'b00000_000_000_0000};
    tbl[18] = '{16'b0_0000_00110_000000, 15'b00000_000_000_0000};
    tbl[19] = '{16'b0_0011_11000_000000, 15'b00000_000_000_0000};
    tbl[20] = '{16'b0_0011_11000_000000, 15'b11000_000_110_0000};
    tbl[21] = '{16'b0_0000_00101_000000, 15'b00100_000_001_0000};
    tbl[22] = '{16'b0_0000_00000_110000, 15'b00000_000_000_0000};
    tbl[23] = '{16'b0_0000_00000_110000, 15'b00010_000_000_0000};
    tbl[24] = '{16'b0_0000_00000_111000, 15'b00010_000_000_1000};
    tbl[25] = '{16'b0_0000_00000_011100, 15'b00000_000_000_0100};
    tbl[26] = '{16'b0_0000_00000_011110, 15'b00001_000_000_0100};
    tbl[27] = '{16'b0_0000_00000_010000, 15'b00000_000_000_0000};
    tbl[28] = '{16'b0_0000_00000_011000, 15'b00010_000_000_0010};
    tbl[29] = '{16'b0_0000_00000_001111, 15'b00001_000_000_0001};
    tbl[30] = '{16'b0_0000_00000_000000, 15'b00000_000_000_0000};

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      apply_in(tbl[i].vin);
      #1;
      chk($sformatf("vec[%0d]", i), 64'(obs()), 64'(tbl[i].vexp));
    end

    // Concurrent s0 write and s1 read: both forwarded one cycle later, payload untouched
    do_reset();
    s0_awaddr = 24'h010004; s0_awprot = 3'b010; s0_wdata = 32'hA5A5A5A5; s0_wstrb = 4'hF;
    s0_awvalid = 1'b1; s0_wvalid = 1'b1;
    s1_araddr = 24'h020008; s1_arprot = 3'b001; s1_arvalid = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    #1;
    chk("conc_awv_n", m_awvalid, 0);
    chk("conc_arv_n", m_arvalid, 0);
    @(negedge clk); #1;
    chk("conc_awv_n1", m_awvalid, 1);
    chk("conc_wv_n1", m_wvalid, 1);
    chk("conc_arv_n1", m_arvalid, 1);
    chk("conc_awaddr", m_awaddr, 24'h010004);
    chk("conc_awprot", m_awprot, 3'b010);
    chk("conc_wdata", m_wdata, 32'hA5A5A5A5);
    chk("conc_wstrb", m_wstrb, 4'hF);
    chk("conc_araddr", m_araddr, 24'h020008);
    chk("conc_arprot", m_arprot, 3'b001);
    @(negedge clk);
    s0_awvalid = 1'b0; s0_wvalid = 1'b0; s1_arvalid = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b10; s0_bready = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b01; s1_rready = 1'b1;
    #1;
    chk("conc_s0_bvalid", s0_bvalid, 1);
    chk("conc_s0_bresp", s0_bresp, 2'b10);
    chk("conc_s1_bresp", s1_bresp, 2'b00);
    chk("conc_s1_rvalid", s1_rvalid, 1);
    chk("conc_s1_rdata", s1_rdata, 32'hCAFEF00D);
    chk("conc_s1_rresp", s1_rresp, 2'b01);
    chk("conc_s0_rdata", s0_rdata, 32'h0);
    chk("conc_s1_bvalid", s1_bvalid, 0);
    @(negedge clk);
    m_bvalid = 1'b0; m_rvalid = 1'b0;
    #1;
    chk("conc_idle_bready", m_bready, 0);
    chk("conc_idle_rready", m_rready, 0);

    // Read tie from reset: s0 first then s1, data routed to the right requester
    do_reset();
    s0_araddr = 24'h000000; s1_araddr = 24'h010000;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b00;
    s0_rready = 1'b1; s1_rready = 1'b1;
    q_ar.delete(); nr0 = 0; nr1 = 0;
    for (int c = 0; c < 30 && (nr0 == 0 || nr1 == 0); c++) begin
      #1;
      if (m_arvalid && m_arready) q_ar.push_back(m_araddr);
      if (s0_rvalid) begin
        nr0++;
        chk("rd_s0_rdata", s0_rdata, 32'h12345678);
        chk("rd_s1_quiet", {s1_rvalid, s1_rdata}, 33'h0);
      end
      if (s1_rvalid) begin
        nr1++;
        chk("rd_s1_rdata", s1_rdata, 32'h12345678);
        chk("rd_s0_quiet", {s0_rvalid, s0_rdata}, 33'h0);
      end
      hs0 = s0_arvalid && s0_arready;
      hs1 = s1_arvalid && s1_arready;
      @(negedge clk);
      if (hs0) s0_arvalid = 1'b0;
      if (hs1) s1_arvalid = 1'b0;
    end
    chk("rd_ar_count", q_ar.size(), 2);
    if (q_ar.size() == 2) begin
      chk("rd_ar_first", q_ar[0], 24'h000000);
      chk("rd_ar_second", q_ar[1], 24'h010000);
    end
    chk("rd_r_count", {nr0[7:0], nr1[7:0]}, 16'h0101);

    // s1 presents w two cycles ahead of aw: exactly one handshake per channel
    do_reset();
    s1_awaddr = 24'h030010; s1_wdata = 32'h0BADBEEF; s1_wstrb = 4'h3;
    s1_wvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_bvalid = 1'b1; m_bresp = 2'b00; s1_bready = 1'b1;
    n_aw = 0; n_w = 0; n_b = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) s1_awvalid = 1'b1;
      #1;
      hs_aw = m_awvalid && m_awready;
      hs_w  = m_wvalid && m_wready;
      hs_b  = s1_bvalid && s1_bready;
      if (hs_aw) begin
        n_aw++;
        chk("wfirst_awaddr", m_awaddr, 24'h030010);
      end
      if (hs_w) begin
        n_w++;
        chk("wfirst_wdata", m_wdata, 32'h0BADBEEF);
        chk("wfirst_wstrb", m_wstrb, 4'h3);
      end
      if (hs_b) n_b++;
      hs0 = s1_awvalid && s1_awready;
      hs1 = s1_wvalid && s1_wready;
      @(negedge clk);
      if (hs0) s1_awvalid = 1'b0;
      if (hs1) s1_wvalid = 1'b0;
    end
    chk("wfirst_aw_count", n_aw, 1);
    chk("wfirst_w_count", n_w, 1);
    chk("wfirst_b_count", n_b, 1);

    // Both requesters write continuously: grants alternate with a 3-cycle cadence
    do_reset();
    s0_awaddr = 24'h000100; s1_awaddr = 24'h000200;
    s0_awvalid = 1'b1; s0_wvalid = 1'b1; s1_awvalid = 1'b1; s1_wvalid = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; s0_bready = 1'b1; s1_bready = 1'b1;
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      #1;
      if (m_awvalid && m_awready) begin
        chk($sformatf("rr_grant[%0d]", k), m_awaddr, (k % 2 == 0) ? 24'h000100 : 24'h000200);
        chk($sformatf("rr_cycle[%0d]", k), c, 1 + 3 * k);
        k++;
      end
      @(negedge clk);
    end
    chk("rr_count", k, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
